// File: rtl/shifter_rev_seq.sv
// shifter_rev_seq: multi-cycle 16-bit shifter (SRL / ASL / ROL).
// An accepted request is processed in greedy steps of 9, 3 or 1 positions,
// one step per RUN cycle, followed by a single-cycle DONE pulse.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   start      request, sampled only in IDLE
//   Shift_In   16-bit operand
//   Shift_Val  shift amount 0..15
//   Mode_In    00 SRL, 01 ASL, 10 ROL, 11 illegal
//   busy       high in RUN
//   done       one-cycle completion pulse (DONE state)
//   Shift_Out  result, held until the next accepted start
//   ovfl       ASL signed-overflow flag, held with Shift_Out
//   err        illegal-mode flag, held with Shift_Out
module shifter_rev_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] Shift_In,
    input  logic [3:0]  Shift_Val,
    input  logic [1:0]  Mode_In,
    output logic        busy,
    output logic        done,
    output logic [15:0] Shift_Out,
    output logic        ovfl,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic [15:0] data_q;
    logic [3:0]  rem_q;
    logic [1:0]  mode_q;
    logic        msb_q;
    logic        ovfl_q;
    logic        err_q;

    logic [4:0]  step;
    logic [15:0] top_mask;
    logic [15:0] step_res;
    logic        step_ovf;

    // Greedy step and its effect on the working operand.
    always_comb begin
        if (rem_q >= 4'd9)
            step = 5'd9;
        else if (rem_q >= 4'd3)
            step = 5'd3;
        else
            step = 5'd1;

        // Bits that leave the top of the word during this step.
        top_mask = ~(16'hFFFF >> step);

        case (mode_q)
            2'b00:   step_res = data_q >> step;
            2'b01:   step_res = data_q << step;
            2'b10:   step_res = (data_q << step) | (data_q >> (5'd16 - step));
            default: step_res = data_q;
        endcase

        // Overflow if an ejected bit or the new sign differs from the
        // original sign; checking the new sign on every step is equivalent
        // to checking only the final one, since earlier ones get ejected.
        step_ovf = (mode_q == 2'b01) &&
                   ((((data_q ^ {16{msb_q}}) & top_mask) != '0) ||
                    (step_res[15] != msb_q));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (Mode_In == 2'b11 || Shift_Val == 4'd0)
                        state_nxt = DONE;
                    else
                        state_nxt = RUN;
                end
            end
            RUN: begin
                if (rem_q == step[3:0])
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        Shift_Out = data_q;
        ovfl      = ovfl_q;
        err       = err_q;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            rem_q  <= '0;
            mode_q <= '0;
            msb_q  <= 1'b0;
            ovfl_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= Mode_In;
                        rem_q  <= Shift_Val;
                        msb_q  <= Shift_In[15];
                        ovfl_q <= 1'b0;
                        err_q  <= (Mode_In == 2'b11);
                        data_q <= (Mode_In == 2'b11) ? '0 : Shift_In;
                    end
                end
                RUN: begin
                    data_q <= step_res;
                    rem_q  <= rem_q - step[3:0];
                    if (step_ovf)
                        ovfl_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
